dvs_event_bus_arbiter_fifo: RTL and testbench



---
 rtl/dvs_event_bus_arbiter_fifo.sv | 136 +++++++++++++
 tb/tb_dvs_event_bus_arbiter_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_event_bus_arbiter_fifo.sv
// Round-robin grant arbiter for NUM_REQ event producers feeding a first-word-fall-through FIFO.
// Optional macro DVS_EVENT_TIMESTAMP_EN prepends a free-running TS_BITS timestamp to each stored event.
package dvs_ravens_pkg;
  localparam int EVENT_BITS = 16;
endpackage

module dvs_event_bus_arbiter_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 16,
  parameter int EVENT_W = EVENT_BITS,
  parameter int TS_BITS = 16,
`ifdef DVS_EVENT_TIMESTAMP_EN
  localparam bit TS_EN  = 1'b1,
`else
  localparam bit TS_EN  = 1'b0,
`endif
  localparam int OUT_W  = EVENT_W + (TS_EN ? TS_BITS : 0),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         fifo_req,
  input  logic [NUM_REQ*EVENT_W-1:0] fifo_bus_event,
  output logic [NUM_REQ-1:0]         fifo_grant,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_event,
  output logic [AW:0]                fill_level
);

  localparam int CW = AW + 1;
  localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state_reg;
  logic [WW-1:0]      last_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      fill_reg;
  logic [OUT_W-1:0]   mem [DEPTH];

  logic [WW-1:0]      winner;
  logic [WW-1:0]      idx;
  logic               found;
  logic               wr_en;
  logic               rd_en;
  logic [EVENT_W-1:0] win_event;
  logic [OUT_W-1:0]   wr_data;
  logic [NUM_REQ-1:0] win_onehot;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = WW'((int'(last_reg) + 1 + k) % NUM_REQ);
      if (!found && fifo_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_event  = fifo_bus_event[int'(winner)*EVENT_W +: EVENT_W];
  assign win_onehot = NUM_REQ'(1) << winner;

  // Eligibility looks at the registered fill count, so a same-cycle pop never frees a slot early.
  assign wr_en = (state_reg == IDLE) && found && (fill_reg != CW'(DEPTH));
  assign rd_en = (fill_reg != '0) && out_ready;

`ifdef DVS_EVENT_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) ts_reg <= '0;
    else        ts_reg <= ts_reg + 1'b1;
  end

  assign wr_data = {ts_reg, win_event};
`else
  assign wr_data = win_event;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      fifo_grant <= '0;
      last_reg   <= WW'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (wr_en) begin
            fifo_grant <= win_onehot;
            last_reg   <= winner;
            state_reg  <= GRANT;
          end
        end
        default: begin
          if (!fifo_req[last_reg]) begin
            fifo_grant <= '0;
            state_reg  <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  assign out_valid  = (fill_reg != '0);
  assign out_event  = mem[rd_ptr_reg];
  assign fill_level = fill_reg;

endmodule

// File: tb/tb_dvs_event_bus_arbiter_fifo.sv
// Directed bench for dvs_event_bus_arbiter_fifo: scoreboard queue of expected events, popped as the consumer accepts them.
module tb_dvs_event_bus_arbiter_fifo;

  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 16;
  localparam int EVENT_W = dvs_ravens_pkg::EVENT_BITS;
  localparam int TS_BITS = 16;
`ifdef DVS_EVENT_TIMESTAMP_EN
  localparam int OUT_W = EVENT_W + TS_BITS;
`else
  localparam int OUT_W = EVENT_W;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         fifo_req = '0;
  logic [NUM_REQ*EVENT_W-1:0] fifo_bus_event = '0;
  logic [NUM_REQ-1:0]         fifo_grant;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [OUT_W-1:0]           out_event;
  logic [$clog2(DEPTH):0]     fill_level;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  logic [EVENT_W-1:0] exp_q[$];
  logic [EVENT_W-1:0] mon_exp;

  dvs_event_bus_arbiter_fifo #(
    .NUM_REQ(NUM_REQ),
    .DEPTH  (DEPTH),
    .EVENT_W(EVENT_W),
    .TS_BITS(TS_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_req      (fifo_req),
    .fifo_bus_event(fifo_bus_event),
    .fifo_grant    (fifo_grant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_event     (out_event),
    .fill_level    (fill_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_event(input int i, input logic [EVENT_W-1:0] v);
    fifo_bus_event[i*EVENT_W +: EVENT_W] = v;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fifo_grant[i] && n < 40);
    check("grant_rise", 64'(fifo_grant[i]), 64'd1);
  endtask

  task automatic send(input int i, input logic [EVENT_W-1:0] v);
    set_event(i, v);
    fifo_req[i] = 1'b1;
    exp_q.push_back(v);
    wait_grant(i);
    fifo_req[i] = 1'b0;
    step();
    check("grant_fall", 64'(fifo_grant[i]), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (fill_level != 0 && n < 40) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check("drain_fill", 64'(fill_level), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer side: every accepted head must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL pop_underflow: observed %0h expected nothing", out_event);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", 64'(out_event[EVENT_W-1:0]), 64'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent [NUM_REQ];
    int ngr;
    int exp_win [4];
    logic [NUM_REQ-1:0] prev;
`ifdef DVS_EVENT_TIMESTAMP_EN
    int c1, c2;
    logic [TS_BITS-1:0] ts1, ts2;
`endif

    // Reset and idle with consumer ready
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("rst_grant", 64'(fifo_grant), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("idle_grant", 64'(fifo_grant), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_fill", 64'(fill_level), 64'd0);
    end
    out_ready = 1'b0;

    // Single producer handshake; the event lands on the grant edge
    set_event(0, 'h155);
    fifo_req[0] = 1'b1;
    exp_q.push_back('h155);
    step();
    check("single_grant_rise", 64'(fifo_grant), 64'b01);
    check("single_fill", 64'(fill_level), 64'd1);
    step();
    check("single_grant_hold", 64'(fifo_grant), 64'b01);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_head", 64'(out_event[EVENT_W-1:0]), 64'h155);
    fifo_req[0] = 1'b0;
    step();
    check("single_grant_fall", 64'(fifo_grant), 64'd0);
    check("single_no_rewrite", 64'(fill_level), 64'd1);
    out_ready = 1'b1;
    step();
    check("single_popped", 64'(fill_level), 64'd0);
    check("single_valid_low", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Two producers competing: round robin from producer 0 after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_win = '{0, 1, 0, 1};
    exp_q.push_back('hA00);
    exp_q.push_back('hA10);
    exp_q.push_back('hA01);
    exp_q.push_back('hA11);
    sent = '{0, 0};
    ngr  = 0;
    prev = '0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_grant[i] && fifo_req[i]) begin
          fifo_req[i] = 1'b0;
          sent[i]++;
        end else if (!fifo_grant[i] && !fifo_req[i] && sent[i] < 2) begin
          set_event(i, EVENT_W'('hA00 + i * 16 + sent[i]));
          fifo_req[i] = 1'b1;
        end
      end
      if (sent[0] == 2 && sent[1] == 2 && fifo_grant == '0) break;
      step();
      if (fifo_grant != '0 && fifo_grant != prev) begin
        check("rr_dead_cycle", 64'(prev), 64'd0);
        if (ngr < 4) check("rr_order", 64'(fifo_grant), 64'(2'b01 << exp_win[ngr]));
        ngr++;
      end
      prev = fifo_grant;
    end
    check("rr_grant_count", 64'(ngr), 64'd4);
    drain();

    // Fill to DEPTH with consumer stalled; extra request must wait
    for (int k = 0; k < DEPTH; k++) send(0, EVENT_W'('hB00 + k));
    check("full_fill", 64'(fill_level), 64'd16);
    set_event(0, 'hB10);
    fifo_req[0] = 1'b1;
    exp_q.push_back('hB10);
    repeat (3) begin
      step();
      check("full_no_grant", 64'(fifo_grant), 64'd0);
      check("full_hold", 64'(fill_level), 64'd16);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("full_pop_fill", 64'(fill_level), 64'd15);
    check("full_pop_no_grant", 64'(fifo_grant), 64'd0);
    step();
    check("full_late_grant", 64'(fifo_grant), 64'b01);
    check("full_refill", 64'(fill_level), 64'd16);
    fifo_req[0] = 1'b0;
    step();
    check("full_grant_fall", 64'(fifo_grant), 64'd0);
    drain();

    // Simultaneous push and pop at fill level 5
    for (int k = 0; k < 5; k++) send(0, EVENT_W'('hC00 + k));
    check("pp_fill_before", 64'(fill_level), 64'd5);
    set_event(0, 'hC05);
    fifo_req[0] = 1'b1;
    exp_q.push_back('hC05);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_grant", 64'(fifo_grant), 64'b01);
    check("pp_fill_same", 64'(fill_level), 64'd5);
    fifo_req[0] = 1'b0;
    step();
    check("pp_fill_after", 64'(fill_level), 64'd5);
    drain();

    // Reset during GRANT with three entries queued
    send(0, 'hD00);
    send(0, 'hD01);
    set_event(0, 'hD02);
    fifo_req[0] = 1'b1;
    exp_q.push_back('hD02);
    step();
    check("rstg_grant", 64'(fifo_grant), 64'b01);
    check("rstg_fill", 64'(fill_level), 64'd3);
    rst_n = 1'b0;
    step();
    check("rstg_grant_drop", 64'(fifo_grant), 64'd0);
    check("rstg_fill_clear", 64'(fill_level), 64'd0);
    check("rstg_valid_clear", 64'(out_valid), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    fifo_req = '0;
    step();
    check("rstg_after", 64'(fill_level), 64'd0);

    // Priority returns to producer 0 after reset
    set_event(0, 'hE00);
    set_event(1, 'hE10);
    fifo_req = 2'b11;
    exp_q.push_back('hE00);
    exp_q.push_back('hE10);
    step();
    check("prio_first", 64'(fifo_grant), 64'b01);
    fifo_req[0] = 1'b0;
    step();
    check("prio_fall", 64'(fifo_grant), 64'd0);
    step();
    check("prio_second", 64'(fifo_grant), 64'b10);
    fifo_req[1] = 1'b0;
    step();
    check("prio_second_fall", 64'(fifo_grant), 64'd0);
    drain();

`ifdef DVS_EVENT_TIMESTAMP_EN
    // Timestamp distance between two writes equals the cycles between their grants
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_event(0, 'hF00);
    fifo_req[0] = 1'b1;
    exp_q.push_back('hF00);
    wait_grant(0);
    c1 = cyc;
    fifo_req[0] = 1'b0;
    repeat (2) step();
    set_event(0, 'hF01);
    fifo_req[0] = 1'b1;
    exp_q.push_back('hF01);
    wait_grant(0);
    c2 = cyc;
    fifo_req[0] = 1'b0;
    step();
    ts1 = out_event[OUT_W-1:EVENT_W];
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ts2 = out_event[OUT_W-1:EVENT_W];
    check("ts_delta", 64'(TS_BITS'(ts2 - ts1)), 64'(TS_BITS'(c2 - c1)));
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
